fcvt_w_s: RTL and testbench

- Single-precision float to signed 32-bit integer converter (RISC-V FCVT.W.S style) for the FPU datapath.
- Rounding is round-to-nearest, ties away from zero.
- Flags out-of-range and NaN/Inf inputs via `exception`.
- Conversion logic is combinational; results are registered, giving one-cycle latency.

---
 rtl/fcvt_w_s.sv | 82 ++++++++
 tb/tb_fcvt_w_s.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fcvt_w_s.sv
// Single-precision float to signed 32-bit integer converter, round to nearest
// with ties away from zero. Combinational convert, one registered stage.
module fcvt_w_s (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic [31:0] y,
  output logic        exception,
  output logic        out_valid
);

  // Handshake: in_valid qualifies x for one cycle; out_valid is in_valid
  // delayed by one cycle and qualifies y/exception. There is no backpressure,
  // so a new operand may be accepted every cycle.

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic [7:0]  exp_w;
  logic [23:0] sig_w;
  logic [4:0]  sh_r;
  logic [2:0]  sh_l;
  logic [24:0] rsh;
  logic [31:0] mag;
  logic        exc_c;

  logic [31:0] y_d, y_q;
  logic        exc_d, exc_q;
  logic        vld_d, vld_q;

  assign exp_w = x[30:23];
  assign sig_w = {1'b1, x[22:0]};

  always_comb begin
    mag   = '0;
    exc_c = 1'b0;
    rsh   = '0;
    sh_r  = 5'(8'd150 - exp_w);
    sh_l  = 3'(exp_w - 8'd150);
    if (exp_w >= 8'd158) begin
      // Covers Inf/NaN (e=255) and every finite value with |x| >= 2^31.
      exc_c = 1'b1;
    end else if (exp_w >= 8'd150) begin
      mag = {8'd0, sig_w} << sh_l;
    end else if (exp_w >= 8'd127) begin
      // Extra low bit catches the guard; sticky bits never matter for ties-away.
      rsh = {sig_w, 1'b0} >> sh_r;
      mag = {8'd0, rsh[24:1]} + {31'd0, rsh[0]};
    end else if (exp_w == 8'd126) begin
      mag = 32'd1;
    end
  end

  always_comb begin
    y_d   = y_q;
    exc_d = exc_q;
    vld_d = in_valid;
    if (in_valid) begin
      exc_d = exc_c;
      if (exc_c)      y_d = INT_MIN;
      else if (x[31]) y_d = -mag;
      else            y_d = mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      exc_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      exc_q <= exc_d;
      vld_q <= vld_d;
    end
  end

  assign y         = y_q;
  assign exception = exc_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_fcvt_w_s.sv
// Bench for fcvt_w_s: directed vectors plus a back-to-back exponent sweep,
// checked by a scoreboard monitor popping expected {exception, y} values.
module tb_fcvt_w_s;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic        in_valid;
  logic [31:0] y;
  logic        exception;
  logic        out_valid;

  int tests;
  int fails;
  logic rst_chk;
  logic [32:0] exp_q[$];

  fcvt_w_s dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .y         (y),
    .exception (exception),
    .out_valid (out_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: exact rational rounding on 64-bit integers.
  function automatic logic [32:0] ref_conv(input logic [31:0] v);
    int unsigned e;
    longint unsigned sig;
    longint unsigned m;
    int unsigned s;
    e   = int'(v[30:23]);
    sig = {40'd0, 1'b1, v[22:0]};
    if (e == 0) return 33'd0;
    if (e == 255) return {1'b1, 32'h8000_0000};
    if (e >= 150) begin
      if (e - 150 > 20) return {1'b1, 32'h8000_0000};
      m = sig << (e - 150);
    end else begin
      s = 150 - e;
      if (s > 40) m = 0;
      else m = (2 * sig + (64'd1 << s)) >> (s + 1);
    end
    if (m >= 64'h8000_0000) return {1'b1, 32'h8000_0000};
    if (v[31]) return {1'b0, 32'(-m)};
    return {1'b0, m[31:0]};
  endfunction

  // Driver tasks
  task automatic send(input logic [31:0] v, input logic [32:0] expv);
    @(posedge clk);
    #1;
    x        = v;
    in_valid = 1'b1;
    exp_q.push_back(expv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = $urandom;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_chk) begin
      tests++;
      if (y !== 32'd0) begin
        fails++;
        $display("FAIL reset_y actual=%h required=00000000", y);
      end
      tests++;
      if (exception !== 1'b0) begin
        fails++;
        $display("FAIL reset_exception actual=%b required=0", exception);
      end
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_out_valid actual=%b required=0", out_valid);
      end
    end else if (out_valid === 1'b1) begin
      logic [32:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output actual=%b_%h required=no output", exception, y);
      end else begin
        e = exp_q.pop_front();
        if ({exception, y} !== e) begin
          fails++;
          $display("FAIL convert actual exc=%b y=%h required exc=%b y=%h",
                   exception, y, e[32], e[31:0]);
        end
      end
    end
  end

  localparam logic [31:0] MIN = 32'h8000_0000;
  logic [31:0] mants[8];

  initial begin
    tests    = 0;
    fails    = 0;
    rst_chk  = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 32'h3F80_0000;

    // Reset with a valid input present: result must be discarded.
    @(posedge clk);
    #1 rst_chk = 1'b1;
    @(posedge clk);
    #1;
    rst_chk  = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(2);

    // Exact and small values
    send(32'h3F80_0000, {1'b0, 32'd1});
    send(32'hC2F6_0000, {1'b0, 32'hFFFF_FF85});
    send(32'h0000_0001, {1'b0, 32'd0});
    send(32'h8000_0000, {1'b0, 32'd0});
    idle(1);

    // Ties and rounding
    send(32'h3F00_0000, {1'b0, 32'd1});
    send(32'hBF00_0000, {1'b0, 32'hFFFF_FFFF});
    send(32'h4020_0000, {1'b0, 32'd3});
    send(32'h3FC0_0000, {1'b0, 32'd2});
    send(32'h3EFF_FFFF, {1'b0, 32'd0});
    send(32'h3F7F_FFFF, {1'b0, 32'd1});
    send(32'hBEFF_FFFF, {1'b0, 32'd0});
    send(32'hC020_0000, {1'b0, 32'hFFFF_FFFD});
    idle(2);

    // Range edge
    send(32'h4EFF_FFFF, {1'b0, 32'h7FFF_FF80});
    send(32'hCEFF_FFFF, {1'b0, 32'h8000_0080});

    // Overflow and specials
    send(32'h4F00_0000, {1'b1, MIN});
    send(32'hCF00_0000, {1'b1, MIN});
    send(32'h7F80_0000, {1'b1, MIN});
    send(32'hFF80_0000, {1'b1, MIN});
    send(32'h7FC0_0000, {1'b1, MIN});
    send(32'h7F7F_FFFF, {1'b1, MIN});
    idle(3);

    // Sweep: every exponent, both signs, back-to-back
    mants = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5FFFFF, 23'h7FFFFF, 23'h0};
    for (int e = 0; e < 256; e++) begin
      for (int sg = 0; sg < 2; sg++) begin
        for (int k = 0; k < 8; k++) begin
          logic [31:0] v;
          logic [22:0] mm;
          mm = (k == 7) ? 23'($urandom_range(0, 32'h7F_FFFF)) : mants[k][22:0];
          v  = {sg[0], e[7:0], mm};
          send(v, ref_conv(v));
        end
      end
    end
    idle(1);

    // Drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
